// File: rtl/xconnect_pkg.sv
// Shared types and helpers for the xconnect round scheduler.
// Field extraction is width-generic so any NOF_PES up to 128 can reuse it.
package xconnect_pkg;

    localparam int NOF_PES_DEFAULT  = 16;
    localparam int NOF_LEVELS       = $clog2(NOF_PES_DEFAULT);
    localparam int GROUP_SIZE_WIDTH = NOF_LEVELS + 1;

    // Upper bounds for the generic field extractor (128 PEs, 8-bit fields).
    localparam int MAX_GW    = 8;
    localparam int MAX_BUS_W = MAX_GW * 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CONFIG,
        ST_WAIT,
        ST_DELIVER
    } state_t;

    // Returns field idx of a packed bus made of gw-bit fields, zero-extended.
    function automatic logic [MAX_GW-1:0] group_size_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   gw
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_GW-1:0]    mask;
        shifted = bus >> (idx * gw);
        mask    = MAX_GW'((1 << gw) - 1);
        return shifted[MAX_GW-1:0] & mask;
    endfunction

endpackage

// File: rtl/xconnect_partition_check.sv
// Combinational legality check of a group partition: every size is a power of
// two within range, and all PEs of each aligned block agree on that size.
module xconnect_partition_check
    import xconnect_pkg::*;
#(
    parameter  int NOF_PES = NOF_PES_DEFAULT,
    localparam int GW      = $clog2(NOF_PES) + 1
) (
    input  logic [GW*NOF_PES-1:0] sizes,
    output logic                  legal
);

    logic [GW-1:0] field [NOF_PES];

    always_comb begin
        for (int i = 0; i < NOF_PES; i++) begin
            field[i] = GW'(group_size_field(MAX_BUS_W'(sizes), i, GW));
        end
    end

    always_comb begin
        int s;
        int block_mask;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        legal      = 1'b1;
        s          = 0;
        block_mask = 0;
        for (int i = 0; i < NOF_PES; i++) begin
            s = int'(field[i]);
            if (s == 0 || s > NOF_PES || (s & (s - 1)) != 0) begin
                legal = 1'b0;
            end else begin
                // PE j shares PE i's aligned block iff their upper index bits match.
                block_mask = ~(s - 1);
                for (int j = 0; j < NOF_PES; j++) begin
                    if ((j & block_mask) == (i & block_mask) && field[j] != field[i]) begin
                        legal = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/xconnect_round_ctrl.sv
// Round scheduler between the PE array and the xconnect crossbar: barrier on
// all PE requests, partition check, timed configuration, data-valid strobe.
module xconnect_round_ctrl
    import xconnect_pkg::*;
#(
    parameter  int NOF_PES          = NOF_PES_DEFAULT,
    parameter  int XCONNECT_LATENCY = 2,
    parameter  int ROUND_CNT_WIDTH  = 16,
    localparam int GW               = $clog2(NOF_PES) + 1,
    localparam int BUS_W            = GW * NOF_PES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NOF_PES-1:0]         pe_req,
    input  logic [BUS_W-1:0]           pe_group_size_bus,
    output logic [NOF_PES-1:0]         pe_ack,
    output logic [BUS_W-1:0]           xconnect_groups_sizes_bus,
    output logic                       xconnect_cfg_valid,
    output logic [NOF_PES-1:0]         pe_data_valid,
    output logic [ROUND_CNT_WIDTH-1:0] round_cnt,
    output logic                       err_illegal,
    output logic                       busy
);

    localparam int LAT_W = $clog2(XCONNECT_LATENCY + 1);

    state_t             state;
    state_t             state_next;
    logic [NOF_PES-1:0] pending;
    logic [NOF_PES-1:0] accept;
    logic [NOF_PES-1:0] pending_collect;
    logic [BUS_W-1:0]   sizes_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               legal;

    assign accept          = (state == ST_IDLE) ? (pe_req & ~pending) : '0;
    assign pending_collect = pending | accept;

    xconnect_partition_check #(.NOF_PES(NOF_PES)) u_check (
        .sizes (sizes_q),
        .legal (legal)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (&pending_collect) state_next = ST_CHECK;
            ST_CHECK:   state_next = legal ? ST_CONFIG : ST_IDLE;
            ST_CONFIG:  state_next = ST_WAIT;
            ST_WAIT:    if (lat_cnt == '0) state_next = ST_DELIVER;
            ST_DELIVER: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        xconnect_cfg_valid = (state == ST_CONFIG) || (state == ST_WAIT) || (state == ST_DELIVER);
        pe_data_valid      = {NOF_PES{state == ST_DELIVER}};
        err_illegal        = (state == ST_CHECK) && !legal;
        busy               = (state != ST_IDLE);
    end

    assign xconnect_groups_sizes_bus = sizes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            lat_cnt   <= '0;
            pe_ack    <= '0;
            round_cnt <= '0;
        end else begin
            state  <= state_next;
            pe_ack <= accept;
            unique case (state)
                ST_IDLE:    pending <= pending_collect;
                ST_CHECK:   if (!legal) pending <= '0;
                ST_CONFIG:  lat_cnt <= LAT_W'(XCONNECT_LATENCY - 1);
                ST_WAIT:    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                ST_DELIVER: begin
                    pending   <= '0;
                    round_cnt <= round_cnt + 1'b1;
                end
                default:    pending <= '0;
            endcase
        end
    end

    // Size register file: a field only loads when its PE's request is accepted,
    // which also confines bus changes to IDLE.
    for (genvar g = 0; g < NOF_PES; g++) begin : g_size_reg
        always_ff @(posedge clk) begin
            // NOTE: this register file is reset on purpose so the xconnect bus reads 0 after reset.
            if (rst) begin
                sizes_q[g*GW +: GW] <= '0;
            end else if (accept[g]) begin
                sizes_q[g*GW +: GW] <= pe_group_size_bus[g*GW +: GW];
            end
        end
    end

endmodule

// File: tb/tb_xconnect_round_ctrl.sv
// Scoreboard bench for xconnect_round_ctrl: expected round outcomes are queued
// when requests are driven and popped when the DUT strobes data-valid or error.
module tb_xconnect_round_ctrl;

    localparam int N   = 16;
    localparam int L   = 2;
    localparam int RCW = 2;
    localparam int GW  = 5;
    localparam int BW  = GW * N;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   pe_req;
    logic [BW-1:0]  pe_group_size_bus;
    logic [N-1:0]   pe_ack;
    logic [BW-1:0]  xconnect_groups_sizes_bus;
    logic           xconnect_cfg_valid;
    logic [N-1:0]   pe_data_valid;
    logic [RCW-1:0] round_cnt;
    logic           err_illegal;
    logic           busy;

    xconnect_round_ctrl #(
        .NOF_PES          (N),
        .XCONNECT_LATENCY (L),
        .ROUND_CNT_WIDTH  (RCW)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .pe_req                    (pe_req),
        .pe_group_size_bus         (pe_group_size_bus),
        .pe_ack                    (pe_ack),
        .xconnect_groups_sizes_bus (xconnect_groups_sizes_bus),
        .xconnect_cfg_valid        (xconnect_cfg_valid),
        .pe_data_valid             (pe_data_valid),
        .round_cnt                 (round_cnt),
        .err_illegal               (err_illegal),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit             is_err;
        int             exp_cycle;
        logic [RCW-1:0] cnt_before;
        logic [BW-1:0]  sizes;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [RCW-1:0] model_cnt = '0;
    logic [N-1:0]   ones_mask = '1;
    int             ack_cnt[N];
    bit             post_valid = 1'b0;
    bit             post_err   = 1'b0;
    logic [RCW-1:0] post_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: ack accounting and scoreboard pops.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) if (pe_ack[i]) ack_cnt[i]++;
            if (post_valid) begin
                check("round_cnt_after", round_cnt, post_cnt);
                if (post_err) check("busy_after_err", busy, 0);
                post_valid = 1'b0;
            end
            if (pe_data_valid != '0 || err_illegal) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {pe_data_valid, err_illegal}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind", err_illegal, mon_e.is_err);
                    check("event_cycle", cyc, mon_e.exp_cycle);
                    check("dv_mask", pe_data_valid, mon_e.is_err ? '0 : ones_mask);
                    check("cfg_valid", xconnect_cfg_valid, !mon_e.is_err);
                    check("round_cnt_at_event", round_cnt, mon_e.cnt_before);
                    if (!mon_e.is_err) check("sizes_bus", xconnect_groups_sizes_bus, mon_e.sizes);
                    post_cnt   = mon_e.is_err ? mon_e.cnt_before : mon_e.cnt_before + 1'b1;
                    post_err   = mon_e.is_err;
                    post_valid = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_sizes(input int s);
        for (int i = 0; i < N; i++) pe_group_size_bus[i*GW +: GW] = GW'(s);
    endtask

    task automatic set_size(input int i, input int s);
        pe_group_size_bus[i*GW +: GW] = GW'(s);
    endtask

    task automatic push_round(input bit is_err, input int exp_cycle);
        exp_t e;
        e.is_err     = is_err;
        e.exp_cycle  = exp_cycle;
        e.cnt_before = model_cnt;
        e.sizes      = pe_group_size_bus;
        sb.push_back(e);
        if (!is_err) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && !post_valid) break;
        end
        if (busy || sb.size() != 0) check("drain_timeout", {busy, 32'(sb.size())}, 0);
    endtask

    // All PEs request in one cycle; legal rounds finish L+2 cycles after the ack.
    task automatic run_all_at_once(input bit is_err);
        int c;
        tick();
        pe_req = '1;
        c      = cyc;
        push_round(is_err, is_err ? c + 1 : c + L + 3);
        tick();
        pe_req = '0;
        @(negedge clk);
        check("ack_all", pe_ack, ones_mask);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           c;
        int           total;
        logic [N-1:0] prev;

        rst               = 1'b1;
        pe_req            = '0;
        pe_group_size_bus = '0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", pe_ack, 0);
        check("rst_cfg_valid", xconnect_cfg_valid, 0);
        check("rst_round_cnt", round_cnt, 0);
        check("rst_sizes_bus", xconnect_groups_sizes_bus, 0);
        tick();
        rst = 1'b0;

        // 1: one full-width group of 16.
        set_all_sizes(16);
        run_all_at_once(1'b0);

        // 2: size 4, staggered from PE15 down to PE0.
        set_all_sizes(4);
        prev = '0;
        for (int k = N - 1; k >= 0; k--) begin
            tick();
            pe_req[k] = 1'b1;
            if (k == 0) begin
                c = cyc;
                push_round(1'b0, c + L + 3);
            end
            @(negedge clk);
            check("stagger_ack", pe_ack, prev);
            check("busy_collect", busy, 0);
            prev = N'(1) << k;
        end
        tick();
        pe_req = '0;
        @(negedge clk);
        check("stagger_last_ack", pe_ack, prev);
        check("busy_check", busy, 1);
        wait_idle();

        // 3: misaligned partition, PE5 claims a group of 4 inside pairs.
        set_all_sizes(2);
        for (int i = 0; i < 4; i++) set_size(i, 4);
        set_size(5, 4);
        run_all_at_once(1'b1);

        // 4: non-power-of-two and zero sizes, then a legal round.
        set_all_sizes(4);
        set_size(3, 3);
        run_all_at_once(1'b1);
        set_size(3, 0);
        run_all_at_once(1'b1);
        set_size(3, 4);
        run_all_at_once(1'b0);

        // 5: reset during WAIT aborts the round.
        set_all_sizes(8);
        tick();
        pe_req = '1;
        tick();
        pe_req = '0;
        tick();
        tick();
        @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_cfg_valid", xconnect_cfg_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        model_cnt = '0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_cfg_valid", xconnect_cfg_valid, 0);
        check("abort_dv", pe_data_valid, 0);
        check("abort_err", err_illegal, 0);
        check("abort_ack", pe_ack, 0);
        check("abort_round_cnt", round_cnt, 0);
        check("abort_sizes_bus", xconnect_groups_sizes_bus, 0);
        repeat (8) tick();

        // 6: PE2 duplicate request, then held requests for four rounds (counter wraps).
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        set_all_sizes(2);
        tick();
        pe_req = N'(1) << 2;
        tick();
        @(negedge clk);
        check("pe2_ack", pe_ack, N'(1) << 2);
        tick();
        pe_req = '1;
        c      = cyc;
        for (int r = 0; r < 4; r++) push_round(1'b0, c + L + 3 + r * (L + 4));
        @(negedge clk);
        check("dup_no_ack", pe_ack, 0);
        for (int k = 0; k < 100 && cyc < c + L + 3 + 3 * (L + 4); k++) tick();
        pe_req = '0;
        wait_idle();
        repeat (4) tick();
        total = 0;
        for (int i = 0; i < N; i++) total += ack_cnt[i];
        check("pe2_ack_count", ack_cnt[2], 4);
        check("total_ack_count", total, 4 * N);
        check("round_cnt_wrap", round_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
